// File: rtl/fetch_queue.sv
// fetch_queue -- first-word-fall-through instruction fetch queue between
// the fetch stage (PC + IM) and decode.
//
// Parameters:
//   DEPTH : number of entries, power of two in 2..16
//   AW    : pointer width, log2(DEPTH)
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous active-high reset (highest priority)
//   flush      : discard every queued entry (branch/jump redirect)
//   in_valid   : fetch presents an entry (in_pc, in_instr)
//   in_ready   : queue can accept an entry this cycle; drives the PC enable
//   out_valid  : head entry valid for decode
//   out_pc     : PC of the head entry (0 while empty)
//   out_instr  : instruction of the head entry (NOP/0 while empty)
//   out_ready  : decode consumes the head this cycle
//   count      : number of occupied entries
//
// All outputs are registers loaded from next-state values, so in_ready has
// no combinational path from out_ready and the head is visible one cycle
// after its push.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   COUNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  // Entry storage (not reset; outputs are forced to 0 while empty)
  logic [31:0] mem_pc_r    [DEPTH];
  logic [31:0] mem_instr_r [DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [31:0]   out_pc_r;
  logic [31:0]   out_instr_r;

  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] wr_next_s;
  logic [AW-1:0] rd_next_s;
  logic [AW:0]   count_next_s;
  logic [31:0]   head_pc_next_s;
  logic [31:0]   head_instr_next_s;

  // Handshakes use only registered ready/valid; flush and reset cancel both
  assign push_s = in_valid  && in_ready_r  && !flush && !reset;
  assign pop_s  = out_valid_r && out_ready && !flush && !reset;

  // Next pointer/count values and the head entry as it will look after the edge
  always_comb begin
    wr_next_s         = wr_ptr_r;
    rd_next_s         = rd_ptr_r;
    count_next_s      = count_r;
    head_pc_next_s    = 32'h0000_0000;
    head_instr_next_s = 32'h0000_0000;

    if (flush) begin
      wr_next_s    = PTR_ZERO;
      rd_next_s    = PTR_ZERO;
      count_next_s = COUNT_ZERO;
    end else begin
      if (push_s) begin
        wr_next_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_next_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_next_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + COUNT_ONE;
        2'b01:   count_next_s = count_r - COUNT_ONE;
        default: count_next_s = count_r;
      endcase
    end

    // The new head is the incoming entry when it lands in the slot the read
    // pointer will point at (queue empty, or one entry popped while pushing)
    if (count_next_s == COUNT_ZERO) begin
      head_pc_next_s    = 32'h0000_0000;
      head_instr_next_s = 32'h0000_0000;
    end else if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_pc_next_s    = in_pc;
      head_instr_next_s = in_instr;
    end else begin
      head_pc_next_s    = mem_pc_r[rd_next_s];
      head_instr_next_s = mem_instr_r[rd_next_s];
    end
  end

  // Storage write: a slot changes only when pushed into
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_pc_r[wr_ptr_r]    <= in_pc;
      mem_instr_r[wr_ptr_r] <= in_instr;
    end
  end

  // Control state and registered outputs; reset beats flush, push and pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= COUNT_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_pc_r    <= 32'h0000_0000;
      out_instr_r <= 32'h0000_0000;
    end else begin
      wr_ptr_r    <= wr_next_s;
      rd_ptr_r    <= rd_next_s;
      count_r     <= count_next_s;
      in_ready_r  <= (count_next_s < COUNT_FULL);
      out_valid_r <= (count_next_s != COUNT_ZERO);
      out_pc_r    <= head_pc_next_s;
      out_instr_r <= head_instr_next_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_pc    = out_pc_r;
  assign out_instr = out_instr_r;
  assign count     = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk_s = 1'b0;
  logic          reset_s;
  logic          flush_s;
  logic          in_valid_s;
  logic [31:0]   in_pc_s;
  logic [31:0]   in_instr_s;
  logic          in_ready_s;
  logic          out_valid_s;
  logic [31:0]   out_pc_s;
  logic [31:0]   out_instr_s;
  logic          out_ready_s;
  logic [AW:0]   count_s;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of {pc, instr}
  logic [63:0] model_q[$];

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk_s),
    .reset     (reset_s),
    .flush     (flush_s),
    .in_valid  (in_valid_s),
    .in_pc     (in_pc_s),
    .in_instr  (in_instr_s),
    .in_ready  (in_ready_s),
    .out_valid (out_valid_s),
    .out_pc    (out_pc_s),
    .out_instr (out_instr_s),
    .out_ready (out_ready_s),
    .count     (count_s)
  );

  // Free-running clock, 10 time units per period
  always #5 clk_s = ~clk_s;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  // Apply one cycle of inputs, advance the model, then compare all outputs
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] pc, input logic ordy);
    bit m_in_ready;
    bit m_out_valid;
    reset_s     = rst;
    flush_s     = fl;
    in_valid_s  = iv;
    in_pc_s     = pc;
    in_instr_s  = instr_of(pc);
    out_ready_s = ordy;
    m_in_ready  = (model_q.size() < DEPTH);
    m_out_valid = (model_q.size() != 0);
    @(posedge clk_s);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      if (m_out_valid && ordy) void'(model_q.pop_front());
      if (iv && m_in_ready) model_q.push_back({pc, instr_of(pc)});
    end
    #1;
    check("count", 64'(count_s), 64'(model_q.size()));
    check("in_ready", 64'(in_ready_s), 64'(model_q.size() < DEPTH));
    check("out_valid", 64'(out_valid_s), 64'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check("out_pc", 64'(out_pc_s), 64'(model_q[0][63:32]));
      check("out_instr", 64'(out_instr_s), 64'(model_q[0][31:0]));
    end else begin
      check("out_pc_empty", 64'(out_pc_s), 64'h0);
      check("out_instr_empty", 64'(out_instr_s), 64'h0);
    end
  endtask

  initial begin
    int pop_idx;
    logic [31:0] exp_pc;
    reset_s = 1'b1; flush_s = 1'b0; in_valid_s = 1'b0;
    in_pc_s = 32'h0; in_instr_s = 32'h0; out_ready_s = 1'b0;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_in_ready", 64'(in_ready_s), 64'h1);

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 32'h3000 + 32'(4*i), 1'b0);
    check("full_count", 64'(count_s), 64'd4);
    check("full_in_ready", 64'(in_ready_s), 64'h0);
    check("full_head", 64'(out_pc_s), 64'h3000);

    // Full plus pop: push refused
    cycle(1'b0, 1'b0, 1'b1, 32'h5000, 1'b1);
    check("fullpop_count", 64'(count_s), 64'd3);
    check("fullpop_head", 64'(out_pc_s), 64'h3004);

    // Flush at count 3 with a simultaneous push of 0x4000
    cycle(1'b0, 1'b1, 1'b1, 32'h4000, 1'b1);
    check("flush_count", 64'(count_s), 64'd0);
    check("flush_valid", 64'(out_valid_s), 64'h0);
    check("flush_instr", 64'(out_instr_s), 64'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("flush_no_4000", 64'(count_s), 64'd0);

    // Steady stream with wrap: 10 pushes with decode always ready
    pop_idx = 0;
    for (int i = 0; i < 11; i++) begin
      if (out_valid_s) begin
        exp_pc = 32'h3000 + 32'(4*pop_idx);
        check("stream_order", 64'(out_pc_s), 64'(exp_pc));
        pop_idx++;
      end
      cycle(1'b0, 1'b0, (i < 10), 32'h3000 + 32'(4*i), 1'b1);
      check("stream_count_le1", 64'(count_s <= 1), 64'h1);
    end
    check("stream_pops", 64'(pop_idx), 64'd10);

    // Reset mid-stream with a push in the reset cycle
    cycle(1'b0, 1'b0, 1'b1, 32'h7000, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h7004, 1'b0);
    check("mid_count2", 64'(count_s), 64'd2);
    cycle(1'b1, 1'b0, 1'b1, 32'h9990, 1'b0);
    check("mid_rst_count", 64'(count_s), 64'd0);
    check("mid_rst_ready", 64'(in_ready_s), 64'h1);
    cycle(1'b0, 1'b0, 1'b1, 32'h3000, 1'b0);
    check("mid_rst_head", 64'(out_pc_s), 64'h3000);

    // Empty pop: drain, then pop attempts while empty, then a fresh push
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("empty_pop_count", 64'(count_s), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'h6000, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h6004, 1'b0);
    check("empty_pop_head", 64'(out_pc_s), 64'h6000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(23) == 0),
            ($urandom_range(3) != 0), $urandom, ($urandom_range(2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two, 2 to 16.
REQ-002 SHALL have parameter AW, default 2, meaning the pointer width; it equals log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: discards all queued entries (branch/jump redirect).
REQ-006 SHALL have port in_valid, input, 1 bit: the fetch stage presents an entry.
REQ-007 SHALL have port in_pc, input, 32 bits: PC of the presented instruction.
REQ-008 SHALL have port in_instr, input, 32 bits: instruction word from IM.
REQ-009 SHALL have port in_ready, output, 1 bit: the queue accepts an entry this cycle; it drives the PC write enable (En).
REQ-010 SHALL have port out_valid, output, 1 bit: the head entry is valid for decode.
REQ-011 SHALL have port out_pc, output, 32 bits: PC of the head entry.
REQ-012 SHALL have port out_instr, output, 32 bits: instruction word of the head entry.
REQ-013 SHALL have port out_ready, input, 1 bit: decode consumes the head this cycle (0 while decode stalls).
REQ-014 SHALL have port count, output, AW+1 bits: number of occupied entries.

Function
REQ-015 SHALL push when in_valid && in_ready; the entry is written at wr_ptr and wr_ptr advances by 1, modulo DEPTH.
REQ-016 SHALL pop when out_valid && out_ready; rd_ptr advances by 1, modulo DEPTH.
REQ-017 SHALL drive in_ready = (count < DEPTH), a function of registered state only, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = (count != 0); the queue is first-word-fall-through, so the head is visible the cycle after the push.
REQ-019 SHALL drive out_pc = 0 and out_instr = 32'h00000000 (NOP) while count == 0.
REQ-020 SHALL leave count unchanged on a simultaneous push and pop, and both pointers advance.
REQ-021 SHALL, when full (count == DEPTH), refuse a push even if a pop occurs in the same cycle; in_ready stays 0 that cycle.
REQ-022 SHALL, when empty, never pop, and a push makes out_valid 1 on the next cycle.
REQ-023 SHALL, on flush, set count, wr_ptr and rd_ptr to 0 on the next edge; flush overrides any concurrent push and pop, and the flushed cycle's input is dropped.
REQ-024 SHALL keep entry contents unchanged except on a push to that slot.
REQ-025 SHALL never let count exceed DEPTH or go below 0.
REQ-026 SHALL preserve strict FIFO order of (pc, instr) pairs, including across pointer wrap-around.
REQ-027 SHALL have a latency of exactly 1 cycle from push to earliest possible pop of that entry.

Reset
REQ-028 SHALL, on reset, set count = 0, wr_ptr = 0, rd_ptr = 0, out_valid = 0, out_pc = 0, out_instr = 0 and in_ready = 1 on the next edge.
REQ-029 SHALL give reset priority over flush, push and pop.
REQ-030 SHALL, on reset mid-operation, discard all entries; a push in the reset cycle is ignored.
REQ-031 SHALL not require reset of storage contents, but outputs SHALL read as 0 while empty regardless of storage.

Verification
REQ-032 SHALL cover fill to full: push 0x3000/0x3004/0x3008/0x300C with out_ready=0 -> count=4, in_ready=0, out_pc=0x3000.
REQ-033 SHALL cover full plus pop: full queue, in_valid=1 and out_ready=1 in one cycle -> push refused, count=3 next, out_pc=0x3004.
REQ-034 SHALL cover steady stream with wrap: 10 consecutive pushes with out_ready=1 -> pops in exact order 0x3000..0x3024, count stays ≤1, no drop.
REQ-035 SHALL cover flush: count=3 plus flush with a simultaneous push of 0x4000 -> count=0, out_valid=0, out_instr=0 next cycle; 0x4000 not present.
REQ-036 SHALL cover reset mid-stream: count=2, reset=1 -> count=0, in_ready=1; the following push of 0x3000 appears at the head one cycle later.
REQ-037 SHALL cover empty pop: out_ready=1 with count=0 -> count stays 0 and pointers are unchanged.
